// File: rtl/spi_slave_rx_mode_if.sv
// Bus bundle between an SPI master/FIFO side and the spi_slave_rx_mode receiver.
// The slave modport is the receiver's view.
interface spi_slave_rx_mode_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DROP_CNT_W = 8
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  cpol;
    logic                  cpha;
    logic                  wr_full;
    logic                  stat_clr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  wr_en;
    logic                  busy;
    logic                  frame_err;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output sclk, cs_n, mosi, cpol, cpha, wr_full, stat_clr,
        input  rx_data, wr_en, busy, frame_err, overflow, drop_cnt
    );

    modport slave (
        input  sclk, cs_n, mosi, cpol, cpha, wr_full, stat_clr,
        output rx_data, wr_en, busy, frame_err, overflow, drop_cnt
    );
endinterface

// File: rtl/spi_slave_rx_mode.sv
// Oversampled SPI slave receiver supporting all four SPI modes, configurable frame
// width and bit order; pushes frames to a FIFO and reports drops and aborted frames.
module spi_slave_rx_mode #(
    parameter int DATA_WIDTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_CNT_W  = 8
) (
    input  logic               wr_clk,
    input  logic               wr_rst_n,
    spi_slave_rx_mode_if.slave bus
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
    logic                   sclkPrev_q, csPrev_q;
    state_t                 state_q, state_d;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d, rxData_q, rxData_d;
    logic                   frameErr_q, frameErr_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  dropCnt_q, dropCnt_d;

    logic sclkS, csS, mosiS;
    logic sclkRise, sclkFall, sampleEdge, csFall, csRise;
    logic frameDone, accept, drop;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            csPrev_q   <= csSync_q[SYNC_STAGES-1];
        end
    end

    assign sclkS      = sclkSync_q[SYNC_STAGES-1];
    assign csS        = csSync_q[SYNC_STAGES-1];
    assign mosiS      = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise   = sclkS & ~sclkPrev_q;
    assign sclkFall   = ~sclkS & sclkPrev_q;
    assign sampleEdge = (cpol_q == cpha_q) ? sclkRise : sclkFall;
    assign csFall     = ~csS & csPrev_q;
    assign csRise     = csS & ~csPrev_q;

    // The cycle after the last sample edge is the completion cycle; wr_full is judged there.
    assign frameDone = (state_q == SHIFT) && (bitCnt_q == FULL_CNT);
    assign accept    = frameDone & ~bus.wr_full;
    assign drop      = frameDone & bus.wr_full;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rxData_q   <= rxData_d;
            frameErr_q <= frameErr_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        frameErr_d = 1'b0;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;

        // A clear and a drop in the same cycle leave exactly one drop recorded.
        if (bus.stat_clr) begin
            overflow_d = 1'b0;
            dropCnt_d  = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dropCnt_d != '1) begin
                dropCnt_d = dropCnt_d + DROP_CNT_W'(1);
            end
        end
        if (accept) begin
            rxData_d = shift_q;
        end

        case (state_q)
            IDLE: begin
                if (csFall) begin
                    state_d  = SHIFT;
                    cpol_d   = bus.cpol;
                    cpha_d   = bus.cpha;
                    bitCnt_d = '0;
                end
            end
            SHIFT: begin
                if (csRise) begin
                    state_d    = IDLE;
                    bitCnt_d   = '0;
                    frameErr_d = (bitCnt_q != '0) && (bitCnt_q != FULL_CNT);
                end else if (frameDone) begin
                    bitCnt_d = '0;
                end else if (sampleEdge) begin
                    if (MSB_FIRST != 0) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], mosiS};
                    end else begin
                        shift_d = {mosiS, shift_q[DATA_WIDTH-1:1]};
                    end
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_en     = accept;
    assign bus.rx_data   = accept ? shift_q : rxData_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.frame_err = frameErr_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = dropCnt_q;
endmodule

// File: doc/spi_slave_rx_mode.md
Name: spi_slave_rx_mode

Overview:
- Parametrised SPI slave receiver in the SPI-to-I2C bridge front end; next generation of the single-mode byte receiver.
- Oversamples `sclk`, `cs_n` and `mosi` in the `wr_clk` domain and supports all four SPI modes, selected at run time.
- Supports configurable frame width and bit order; pushes each completed frame to the downstream FIFO with a one-cycle `wr_en` pulse.
- Reports dropped frames (FIFO full) and aborted frames (`cs_n` released mid-frame) through status outputs.

Parameters:
- DATA_WIDTH, 8: bits per SPI frame; legal range 4..32.
- MSB_FIRST, 1: 1 = first received bit lands in `rx_data[DATA_WIDTH-1]`; 0 = first bit lands in `rx_data[0]`.
- SYNC_STAGES, 2: synchroniser depth applied identically to `sclk`, `cs_n` and `mosi`; minimum 2.
- DROP_CNT_W, 8: width of the saturating drop counter.

Ports:
- wr_clk  in  1  system clock; all logic on its rising edge.
- wr_rst_n  in  1  reset; synchronous, active-low.
- sclk  in  1  SPI clock from master, asynchronous.
- cs_n  in  1  chip select from master, active-low, asynchronous.
- mosi  in  1  serial data from master, asynchronous.
- cpol  in  1  clock polarity; latched at frame start.
- cpha  in  1  clock phase; latched at frame start.
- wr_full  in  1  downstream FIFO full.
- stat_clr  in  1  one-cycle pulse; clears `drop_cnt` and `overflow`.
- rx_data  out  DATA_WIDTH  last completed frame.
- wr_en  out  1  one-cycle FIFO write strobe.
- busy  out  1  high while a frame is in progress (SHIFT state).
- frame_err  out  1  one-cycle pulse on an aborted frame.
- overflow  out  1  sticky; set when any frame is dropped.
- drop_cnt  out  DROP_CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (`wr_rst_n` low at a `wr_clk` edge): all outputs 0. Synchroniser flops reset to `sclk`=0, `cs_n`=1, `mosi`=0. FSM goes to IDLE; bit counter and shift register cleared.
- Synchronisation: `sclk`, `cs_n` and `mosi` each pass through SYNC_STAGES flops, so data stays aligned with the detected clock edge.
- Edge detect: compare synchronised `sclk` with its one-cycle-delayed copy.
- Sample edge: rising when the latched `cpol` equals the latched `cpha`; falling otherwise.
- FSM states: IDLE and SHIFT.
- IDLE:
  - synchronised `cs_n` high; all `sclk` edges ignored.
  - On synchronised `cs_n` falling: latch `cpol`/`cpha` into the mode register, clear the bit counter, go to SHIFT.
  - `cpol`/`cpha` changes while in SHIFT have no effect.
- SHIFT, on each detected sample edge:
  - Shift synchronised `mosi` in, direction per MSB_FIRST.
  - Bit counter increments. Counter width is clog2(DATA_WIDTH+1).
- Frame completion: the sample edge of bit DATA_WIDTH is detected in cycle N.
  - Cycle N+1, `wr_full`=0: `rx_data` = assembled frame, `wr_en`=1 for exactly one cycle.
  - Cycle N+1, `wr_full`=1: `rx_data` unchanged, `wr_en`=0, `overflow` set, `drop_cnt` increments (saturates at all-ones).
  - Either way the bit counter returns to 0 and the FSM stays in SHIFT, so back-to-back frames need no gap.
- No extra `sclk` edge is needed to flush a frame.
- `wr_full` is examined only in the completion cycle; the receiver never stalls SPI.
- `rx_data` holds its value until the next accepted frame.
- Synchronised `cs_n` rising while in SHIFT: return to IDLE.
  - Bit counter 1..DATA_WIDTH-1: the partial frame is discarded and `frame_err` pulses for one cycle.
  - Bit counter 0: no error.
- Simultaneous `cs_n` deassertion and sample edge in the same cycle: deassertion wins. The edge is ignored and the counter value before that edge decides `frame_err`.
- `stat_clr` and a drop in the same cycle: clear first, then increment. Result: `drop_cnt`=1, `overflow`=1.
- `busy` = (state == SHIFT).
- A reset asserted mid-frame aborts without a `frame_err` pulse.
- Timing requirement: `sclk` high and low phases must each be at least SYNC_STAGES+1 `wr_clk` periods.

Test Plan:
- Mode 0, MSB_FIRST=1, DATA_WIDTH=8: send 0xA5 then 0x3C back-to-back under one `cs_n` -> two `wr_en` pulses, `rx_data`=0xA5 then 0x3C, `frame_err`=0.
- Modes 1, 2 and 3 in turn, each sending 0x96 with the `cpol`/`cpha` setting changed between frames while `cs_n` is high -> `rx_data`=0x96 each time. Toggling `cpol` mid-frame must not corrupt the frame.
- Instantiate with MSB_FIRST=0, DATA_WIDTH=16; send bit stream for 0x1234 LSB first -> `rx_data`=0x1234, one `wr_en` pulse.
- Hold `wr_full`=1 and send 3 frames -> `wr_en` never asserted, `drop_cnt`=3, `overflow`=1, `rx_data` unchanged. Then pulse `stat_clr` -> `drop_cnt`=0, `overflow`=0. With DROP_CNT_W=2 and 5 drops -> `drop_cnt`=3.
- Deassert `cs_n` after 5 bits -> `frame_err` pulses once, no `wr_en`. A following full 0xFF frame is received correctly.
- Assert `wr_rst_n`=0 mid-frame after 4 bits, release, then send 0x81 -> all outputs 0 during reset, `rx_data`=0x81 after the frame, no `frame_err`.
